uart_tx_fifo: RTL and testbench

//  Buffers bytes from the CPU/PIA side and feeds them one at a time to async_transmitter.

---
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that paces a UART transmitter through its start/busy handshake
// Write side pushes bytes; a small FSM pops one byte per frame whenever the transmitter is idle.
module uart_tx_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_flush,
  input  logic                  i_clr_ovf,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_wait_cnt;
  logic                  w_wait_cnt_next;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_start_next;

  assign w_push = i_wr_en & ~r_full;

  // A flush cycle suppresses the pop so a discarded byte is never started.
  always_comb begin
    w_state_next    = r_state;
    w_pop           = 1'b0;
    w_start_next    = 1'b0;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (!r_empty && !i_tx_busy && !i_flush) begin
          w_pop        = 1'b1;
          w_start_next = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        w_wait_cnt_next = 1'b0;
        w_state_next    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_state_next = WAIT_DONE;
        end else if (r_wait_cnt) begin
          w_state_next = IDLE;
        end else begin
          w_wait_cnt_next = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (i_flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_count    <= w_count_next;
      r_full     <= (w_count_next == CNT_DEPTH);
      r_empty    <= (w_count_next == '0);
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      // A rejected write outranks a same-cycle clear.
      if (i_wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
        r_overflow <= 1'b0;
      end
      r_tx_start <= w_start_next;
      if (w_start_next) begin
        r_tx_data <= r_mem[r_rd_ptr];
      end
    end
  end

  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a transmitter busy stub
// A queue/timestamp model predicts the outputs every cycle; directed tests pin exact values.
module tb_uart_tx_fifo;

  localparam int FRAME = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  logic       force_hi;
  logic       mute;
  logic       stub_busy;
  logic       chk_en;

  int n_checks = 0;
  int n_fail   = 0;

  assign tx_busy = force_hi | stub_busy;

  uart_tx_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_flush(flush), .i_clr_ovf(clr_ovf), .o_full(full), .o_empty(empty),
    .o_count(count), .o_overflow(overflow), .o_tx_start(tx_start),
    .o_tx_data(tx_data), .i_tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO contents as a queue; the start engine is free again one edge after busy is
  // seen low, or four edges after a start whose busy never showed up within two edges.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_start = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         eng = 1'b0;
  int         cyc = 0;
  int         s_e = 0;
  int         h_e = -1;
  int         free_at = 0;
  logic       full_pre;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_start = 1'b0; m_data = 8'h00;
      eng = 1'b0; h_e = -1; free_at = 0;
    end else begin
      cyc++;
      full_pre = (mq.size() == 16);
      if (eng) begin
        if (h_e < 0) begin
          if ((cyc == s_e + 2 || cyc == s_e + 3) && tx_busy) h_e = cyc;
          else if (cyc == s_e + 3) begin eng = 1'b0; free_at = cyc + 1; end
        end else if (!tx_busy) begin
          eng = 1'b0; free_at = cyc + 1;
        end
      end
      m_start = 1'b0;
      if (!eng && cyc >= free_at && mq.size() != 0 && !tx_busy && !flush) begin
        m_start = 1'b1; m_data = mq.pop_front(); eng = 1'b1; s_e = cyc; h_e = -1;
      end
      if (flush) mq.delete();
      else if (wr_en && !full_pre) mq.push_back(wr_data);
      if (wr_en && full_pre) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst && chk_en) begin
      check("m_count", 32'(count), 32'(mq.size()));
      check("m_full", 32'(full), 32'(mq.size() == 16));
      check("m_empty", 32'(empty), 32'(mq.size() == 0));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
      check("m_tx_start", 32'(tx_start), 32'(m_start));
      check("m_tx_data", 32'(tx_data), 32'(m_data));
    end
  end

  // Transmitter stub: busy for FRAME cycles after each start unless muted.
  logic [7:0] sent[$];
  int         start_nc[$];
  int         nc = 0;
  int         bcnt = 0;
  int         fall_nc = 0;
  bit         fall_valid = 1'b0;
  int         maxgap = 0;
  int         n_gaps = 0;

  always @(negedge clk) begin
    nc++;
    if (rst) begin
      stub_busy = 1'b0; bcnt = 0;
    end else begin
      if (tx_start) begin
        sent.push_back(tx_data);
        start_nc.push_back(nc);
        if (fall_valid) begin
          if (nc - fall_nc > maxgap) maxgap = nc - fall_nc;
          n_gaps++;
          fall_valid = 1'b0;
        end
      end
      if (stub_busy) begin
        bcnt--;
        if (bcnt == 0) begin stub_busy = 1'b0; fall_nc = nc; fall_valid = 1'b1; end
      end else if (tx_start && !mute) begin
        stub_busy = 1'b1; bcnt = FRAME;
      end
    end
  end

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_sent(input int target, input string name);
    int k = 0;
    while ((sent.size() < target || tx_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, 32'(k < 3000), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; clr_ovf = 1'b0;
    force_hi = 1'b0; mute = 1'b0; stub_busy = 1'b0; chk_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);

    // T1 single byte latency
    wr(8'h41);
    check("t1_empty_n", 32'(empty), 32'd0);
    check("t1_count_n", 32'(count), 32'd1);
    check("t1_start_n", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("t1_start_n1", 32'(tx_start), 32'd1);
    check("t1_data_n1", 32'(tx_data), 32'h41);
    check("t1_count_n1", 32'(count), 32'd0);
    @(negedge clk);
    check("t1_start_n2", 32'(tx_start), 32'd0);
    wait_sent(1, "t1");
    check("t1_empty_end", 32'(empty), 32'd1);
    check("t1_byte", 32'(sent[0]), 32'h41);

    // T2 burst of 16
    fall_valid = 1'b0; maxgap = 0; n_gaps = 0;
    for (int i = 0; i < 16; i++) wr(8'(i));
    wait_sent(17, "t2");
    for (int i = 0; i < 16; i++) check("t2_order", 32'(sent[1 + i]), 32'(i));
    check("t2_max_gap", 32'(maxgap), 32'd2);
    check("t2_n_gaps", 32'(n_gaps), 32'd15);

    // T3 overflow with transmitter held busy
    force_hi = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) wr(8'h80 + 8'(i));
    check("t3_count", 32'(count), 32'd16);
    check("t3_full", 32'(full), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    force_hi = 1'b0;
    wait_sent(33, "t3");
    check("t3_last_kept", 32'(sent[32]), 32'h8F);

    // T4 push in the same cycle as a pop
    force_hi = 1'b1;
    @(negedge clk);
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    check("t4_count_pre", 32'(count), 32'd3);
    force_hi = 1'b0; wr_en = 1'b1; wr_data = 8'hA4;
    @(negedge clk);
    wr_en = 1'b0;
    check("t4_count", 32'(count), 32'd3);
    check("t4_start", 32'(tx_start), 32'd1);
    check("t4_data", 32'(tx_data), 32'hA1);
    wait_sent(37, "t4");
    for (int i = 0; i < 4; i++) check("t4_order", 32'(sent[33 + i]), 32'hA1 + 32'(i));

    // T5 flush while the first frame is in flight
    base = sent.size();
    wr(8'hB1); wr(8'hB2); wr(8'hB3); wr(8'hB4);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t5_count_flush", 32'(count), 32'd0);
    check("t5_empty_flush", 32'(empty), 32'd1);
    repeat (60) @(negedge clk);
    check("t5_frames", 32'(sent.size() - base), 32'd1);
    check("t5_byte", 32'(sent[base]), 32'hB1);

    // Missed start: busy never rises, next start four cycles later
    mute = 1'b1;
    base = start_nc.size();
    wr(8'hC1); wr(8'hC2);
    repeat (15) @(negedge clk);
    check("t7_starts", 32'(start_nc.size() - base), 32'd2);
    check("t7_spacing", 32'(start_nc[base + 1] - start_nc[base]), 32'd4);
    mute = 1'b0;
    repeat (4) @(negedge clk);

    // T6 reset mid-frame
    wr(8'h33);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_count", 32'(count), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_start", 32'(tx_start), 32'd0);
    check("t6_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = sent.size();
    wr(8'h5A);
    wait_sent(base + 1, "t6");
    check("t6_byte", 32'(sent[base]), 32'h5A);
    check("t6_empty_end", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
